// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute/writeback sequencer.
//   - sequencer state encoding
//   - opcode values
//   - bit positions of the {Z,N,C,V} flag vector
//   - field positions inside the 16-bit decoded instruction
package exec_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 8;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU for exec_ctrl.
// Ports:
//   a, b      operands (register file read data A/B)
//   imm       immediate for LDI
//   opcode    4-bit opcode
//   flags_in  current {Z,N,C,V}; passed through for ops that hold flags
//   result    ALU result
//   flags     next {Z,N,C,V}
//   wb_en     result is to be written to rd
//   illegal   opcode is undefined
module alu_core
  import exec_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  logic [3:0]    opcode,
  input  logic [3:0]    flags_in,
  output logic [DW-1:0] result,
  output logic [3:0]    flags,
  output logic          wb_en,
  output logic          illegal
);

  logic          sub;
  logic [DW-1:0] b_op;
  logic [DW:0]   sum;
  logic          upd;
  logic          c;
  logic          v;

  // One adder serves ADD, SUB and CMP; subtraction is a + ~b + 1.
  assign sub  = (opcode == OP_SUB) || (opcode == OP_CMP);
  assign b_op = sub ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, b_op} + {{DW{1'b0}}, sub};

  always_comb begin
    result  = '0;
    wb_en   = 1'b0;
    illegal = 1'b0;
    upd     = 1'b0;
    c       = 1'b0;
    v       = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_CMP: begin
        result = sum[DW-1:0];
        wb_en  = (opcode != OP_CMP);
        upd    = 1'b1;
        c      = sum[DW];
        // Overflow: both addends share a sign that the sum does not.
        v      = (a[DW-1] == b_op[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_AND: begin result = a & b; wb_en = 1'b1; upd = 1'b1; end
      OP_OR:  begin result = a | b; wb_en = 1'b1; upd = 1'b1; end
      OP_XOR: begin result = a ^ b; wb_en = 1'b1; upd = 1'b1; end
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
        wb_en  = 1'b1;
        upd    = 1'b1;
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
        wb_en  = 1'b1;
        upd    = 1'b1;
      end
      OP_MOV: begin result = a;   wb_en = 1'b1; end
      OP_LDI: begin result = imm; wb_en = 1'b1; end
      default: illegal = 1'b1;
    endcase

    flags = flags_in;
    if (upd) begin
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[DW-1];
      flags[FLAG_C] = c;
      flags[FLAG_V] = v;
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: serialised execute/writeback sequencer around an 8x8 register file.
// One instruction in flight: IDLE (accept) -> EXEC (read, compute) -> WB (write, retire).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   instr_valid/ready      instruction handshake; ready is registered, high only in IDLE
//   instr                  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm
//   radda, raddb           register file read addresses (latched rs1/rs2)
//   ra, rb                 register file read data (combinational from radda/raddb)
//   w, wadd, wdata         register file write port
//   flags                  registered {Z,N,C,V}
//   done, illegal          one-cycle pulses at retire
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [AW-1:0] radda,
  output logic [AW-1:0] raddb,
  input  logic [DW-1:0] ra,
  input  logic [DW-1:0] rb,
  output logic          w,
  output logic [AW-1:0] wadd,
  output logic [DW-1:0] wdata,
  output logic [3:0]    flags,
  output logic          done,
  output logic          illegal
);

  state_e        state_q, state_d;
  logic          ready_q;
  logic [3:0]    opcode_q;
  logic [DW-1:0] imm_q;
  logic [AW-1:0] radda_q, raddb_q, wadd_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    flags_q;
  logic          wb_en_q;
  logic          illegal_q;
  logic          accept;

  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic          alu_wb_en;
  logic          alu_illegal;

  alu_core #(
    .DW (DW)
  ) u_alu (
    .a        (ra),
    .b        (rb),
    .imm      (imm_q),
    .opcode   (opcode_q),
    .flags_in (flags_q),
    .result   (alu_result),
    .flags    (alu_flags),
    .wb_en    (alu_wb_en),
    .illegal  (alu_illegal)
  );

  assign accept = (state_q == StIdle) && ready_q && instr_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      opcode_q  <= OP_NOP;
      imm_q     <= '0;
      radda_q   <= '0;
      raddb_q   <= '0;
      wadd_q    <= '0;
      wdata_q   <= '0;
      flags_q   <= '0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      if (accept) begin
        opcode_q <= instr[OPC_LSB +: OPC_W];
        imm_q    <= DW'(instr[IMM_LSB +: IMM_W]);
        wadd_q   <= instr[RD_LSB +: AW];
        radda_q  <= instr[RS1_LSB +: AW];
        raddb_q  <= instr[RS2_LSB +: AW];
      end
      if (state_q == StExec) begin
        wb_en_q   <= alu_wb_en;
        illegal_q <= alu_illegal;
        flags_q   <= alu_flags;
        // wdata keeps the last written value across non-writing ops.
        if (alu_wb_en) wdata_q <= alu_result;
      end
    end
  end

  always_comb begin
    w       = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    if (state_q == StWb) begin
      // Gate with rst_n so a reset edge landing in WB never writes.
      w       = wb_en_q && rst_n;
      done    = 1'b1;
      illegal = illegal_q;
    end
  end

  assign instr_ready = ready_q;
  assign radda       = radda_q;
  assign raddb       = raddb_q;
  assign wadd        = wadd_q;
  assign wdata       = wdata_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  radda, raddb, wadd;
  logic [7:0]  ra, rb, wdata;
  logic        w, done, illegal;
  logic [3:0]  flags;

  logic [7:0]  regs [8];
  logic        rf_clr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mregs [8];
  logic [3:0] mflags;
  bit         e_wen, e_ill;
  logic [7:0] e_res;
  logic [3:0] e_flags;
  logic [2:0] e_rd, e_rs1;

  // Observations from one instruction: index 0 = EXEC, 1 = WB, 2 = following cycle
  logic [2:0] obs_w, obs_done, obs_ill, obs_rdy;
  logic [7:0] obs_wdata;
  logic [2:0] obs_wadd, obs_ra_exec;
  logic [3:0] obs_flags;
  bit         obs_to;

  always #5 clk = ~clk;

  exec_ctrl #(
    .DW (8),
    .AW (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .radda       (radda),
    .raddb       (raddb),
    .ra          (ra),
    .rb          (rb),
    .w           (w),
    .wadd        (wadd),
    .wdata       (wdata),
    .flags       (flags),
    .done        (done),
    .illegal     (illegal)
  );

  // 8x8 register file: asynchronous read, synchronous write
  assign ra = regs[radda];
  assign rb = regs[raddb];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (w) begin
      regs[wadd] <= wdata;
    end
  end

  // Model one instruction from the opcode table with integer arithmetic, then commit it.
  task automatic model_step(input logic [15:0] ins);
    int a, b, sa, sb, r, sr;
    bit upd, c, v;
    logic [3:0] op;
    op = ins[15:12];
    e_rd = ins[11:9];
    e_rs1 = ins[8:6];
    a = int'(mregs[ins[8:6]]);
    b = int'(mregs[ins[5:3]]);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    e_wen = 0; e_ill = 0; upd = 0; c = 0; v = 0; r = 0; sr = 0;
    case (op)
      4'h0: ;
      4'h1: begin
        r = a + b; sr = sa + sb; c = (r > 255); v = (sr > 127) || (sr < -128);
        upd = 1; e_wen = 1;
      end
      4'h2, 4'hA: begin
        r = a - b; sr = sa - sb; c = (a >= b); v = (sr > 127) || (sr < -128);
        upd = 1; e_wen = (op == 4'h2);
      end
      4'h3: begin r = a & b; upd = 1; e_wen = 1; end
      4'h4: begin r = a | b; upd = 1; e_wen = 1; end
      4'h5: begin r = a ^ b; upd = 1; e_wen = 1; end
      4'h6: begin r = a * 2; c = (a >= 128); upd = 1; e_wen = 1; end
      4'h7: begin r = a / 2; c = (a % 2) == 1; upd = 1; e_wen = 1; end
      4'h8: begin r = a; e_wen = 1; end
      4'h9: begin r = int'(ins[7:0]); e_wen = 1; end
      default: e_ill = 1;
    endcase
    e_res = 8'(r & 255);
    e_flags = upd ? {e_res == 8'h00, e_res >= 8'd128, c, v} : mflags;
    if (e_wen) mregs[e_rd] = e_res;
    mflags = e_flags;
  endtask

  // Present one instruction and record the three cycles that follow its accept edge.
  task automatic run_instr(input logic [15:0] ins);
    int n = 0;
    obs_to = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin obs_to = 1; return; end
    instr = ins;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        instr_valid = 1'b0;
        instr = 16'($urandom);
        obs_ra_exec = radda;
      end
      obs_w[k] = w; obs_done[k] = done; obs_ill[k] = illegal; obs_rdy[k] = instr_ready;
      if (k == 1) begin obs_wdata = wdata; obs_wadd = wadd; obs_flags = flags; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({instr_ready, done, illegal, w} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl got %b want 0000", {instr_ready, done, illegal, w}); end
    checks++; if ({flags, wdata} !== 12'h000) begin errors++;
      $display("FAIL reset_data flags %b wdata %h want 0", flags, wdata); end
    checks++; if ({radda, raddb, wadd} !== 9'd0) begin errors++;
      $display("FAIL reset_addr got %h %h %h want 0", radda, raddb, wadd); end
    rf_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready got %b want 1", instr_ready); end
  endtask

  task automatic test_load();
    model_step(16'h927F); run_instr(16'h927F);
    checks++; if (obs_to !== 1'b0 || obs_w !== 3'b010) begin errors++;
      $display("FAIL ldi1_w got %b want 010 (timeout %0d)", obs_w, obs_to); end
    checks++; if (regs[1] !== 8'h7F) begin errors++;
      $display("FAIL ldi1_r1 got %h want 7f", regs[1]); end
    model_step(16'h9401); run_instr(16'h9401);
    checks++; if (obs_to !== 1'b0 || obs_w !== 3'b010) begin errors++;
      $display("FAIL ldi2_w got %b want 010 (timeout %0d)", obs_w, obs_to); end
    checks++; if (regs[2] !== 8'h01 || flags !== 4'b0000) begin errors++;
      $display("FAIL ldi2_r2 got %h flags %b want 01 0000", regs[2], flags); end
  endtask

  task automatic test_add_overflow();
    model_step(16'h1650); run_instr(16'h1650);
    checks++; if (obs_wdata !== 8'h80 || obs_w !== 3'b010) begin errors++;
      $display("FAIL add_wdata got %h w %b want 80 010", obs_wdata, obs_w); end
    checks++; if (regs[3] !== 8'h80) begin errors++;
      $display("FAIL add_r3 got %h want 80", regs[3]); end
    checks++; if (obs_flags !== 4'b0101) begin errors++;
      $display("FAIL add_flags got %b want 0101", obs_flags); end
  endtask

  task automatic test_sub_cmp();
    model_step(16'h2890); run_instr(16'h2890);
    checks++; if (regs[4] !== 8'h00 || obs_flags !== 4'b1010) begin errors++;
      $display("FAIL sub_zero r4 %h flags %b want 00 1010", regs[4], obs_flags); end
    model_step(16'hA890); run_instr(16'hA890);
    checks++; if (obs_flags !== 4'b1010 || obs_w !== 3'b000) begin errors++;
      $display("FAIL cmp flags %b w %b want 1010 000", obs_flags, obs_w); end
  endtask

  task automatic test_shift_illegal();
    model_step(16'h7A40); run_instr(16'h7A40);
    checks++; if (regs[5] !== 8'h3F || obs_flags !== 4'b0010) begin errors++;
      $display("FAIL shr r5 %h flags %b want 3f 0010", regs[5], obs_flags); end
    model_step(16'hF000); run_instr(16'hF000);
    checks++; if (obs_done !== 3'b010 || obs_ill !== 3'b010 || obs_w !== 3'b000) begin
      errors++;
      $display("FAIL illegal done %b ill %b w %b want 010 010 000", obs_done, obs_ill, obs_w);
    end
    checks++; if (obs_flags !== 4'b0010) begin errors++;
      $display("FAIL illegal_flags got %b want 0010", obs_flags); end
  endtask

  task automatic test_backpressure();
    logic [15:0] q [3];
    logic [11:0] rdy_pat;
    int idx = 0, n = 0, wcnt = 0, dcnt = 0;
    q[0] = 16'h1C50; q[1] = 16'h5E50; q[2] = 16'h9055;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 12; k++) begin
      rdy_pat[11-k] = instr_ready;
      wcnt += int'(w);
      dcnt += int'(done);
      if (instr_ready && idx < 3) begin
        instr = q[idx]; instr_valid = 1'b1; model_step(q[idx]); idx++;
      end else if (idx < 3) begin
        instr = 16'($urandom);
      end else begin
        instr_valid = 1'b0; instr = 16'($urandom);
      end
      @(negedge clk);
    end
    checks++; if (rdy_pat !== 12'b100100100111) begin errors++;
      $display("FAIL bp_ready got %b want 100100100111", rdy_pat); end
    checks++; if (wcnt != 3 || dcnt != 3) begin errors++;
      $display("FAIL bp_retire writes %0d dones %0d want 3 3", wcnt, dcnt); end
    checks++; if ({regs[6], regs[7], regs[0]} !== 24'h807E55) begin errors++;
      $display("FAIL bp_regs got %h %h %h want 80 7e 55", regs[6], regs[7], regs[0]); end
    checks++; if (flags !== 4'b0000) begin errors++;
      $display("FAIL bp_flags got %b want 0000", flags); end
  endtask

  task automatic test_reset_midop();
    int n = 0, wcnt = 0;
    model_step(16'h9611); run_instr(16'h9611);
    checks++; if (regs[3] !== 8'h11) begin errors++;
      $display("FAIL midop_setup r3 %h want 11", regs[3]); end
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    instr = 16'h1650; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    wcnt += int'(w);
    @(negedge clk);
    rst_n = 1'b1;
    wcnt += int'(w);
    @(negedge clk);
    wcnt += int'(w);
    checks++; if (instr_ready !== 1'b1) begin errors++;
      $display("FAIL midop_ready got %b want 1", instr_ready); end
    repeat (3) begin @(negedge clk); wcnt += int'(w); end
    mflags = 4'b0000;
    checks++; if (wcnt != 0 || regs[3] !== 8'h11) begin errors++;
      $display("FAIL midop_write writes %0d r3 %h want 0 11", wcnt, regs[3]); end
    checks++; if (flags !== 4'b0000 || done !== 1'b0) begin errors++;
      $display("FAIL midop_flags got %b done %b want 0000 0", flags, done); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      ins[15:12] = (n % 4 == 3) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      model_step(ins);
      run_instr(ins);
      checks++; if (obs_to !== 1'b0 || obs_done !== 3'b010 || obs_rdy !== 3'b100) begin
        errors++;
        $display("FAIL rnd_timing ins %h done %b rdy %b want 010 100", ins, obs_done, obs_rdy);
      end
      checks++; if (obs_w !== (e_wen ? 3'b010 : 3'b000) || obs_ill !== (e_ill ? 3'b010 : 3'b000))
      begin
        errors++;
        $display("FAIL rnd_ctrl ins %h w %b ill %b want %0d %0d", ins, obs_w, obs_ill, e_wen,
                 e_ill);
      end
      checks++; if (obs_flags !== e_flags || obs_ra_exec !== e_rs1) begin errors++;
        $display("FAIL rnd_flags ins %h flags %b radda %0d want %b %0d", ins, obs_flags,
                 obs_ra_exec, e_flags, e_rs1);
      end
      if (e_wen) begin
        checks++; if (obs_wdata !== e_res || obs_wadd !== e_rd) begin errors++;
          $display("FAIL rnd_wdata ins %h got %h@%0d want %h@%0d", ins, obs_wdata, obs_wadd,
                   e_res, e_rd);
        end
      end
      checks++; if (regs[e_rd] !== mregs[e_rd]) begin errors++;
        $display("FAIL rnd_reg ins %h r%0d got %h want %h", ins, e_rd, regs[e_rd], mregs[e_rd]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rf_clr = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mflags = 4'b0000;
    test_reset();
    test_load();
    test_add_overflow();
    test_sub_cmp();
    test_shift_illegal();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
